// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - LED pattern sequencer: tick prescaler plus off/on/blink/burst FSM
// Outputs are all registered; led feeds the downstream LED flop.
module blink_sequencer #(
  parameter int DIV   = 12000000,
  parameter int CNT_W = 24,
  parameter int BURST = 3,
  parameter int PAUSE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       led,
  output logic       tick,
  output logic       burst_done
);

  localparam int BW = $clog2(BURST + 1);
  localparam int PW = (PAUSE > 1) ? $clog2(PAUSE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [BW-1:0]    BURST_MAX = BW'(BURST);
  localparam logic [PW-1:0]    PAUSE_MAX = PW'(PAUSE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    ON_PH  = 3'd2,
    OFF_PH = 3'd3,
    PAUSE_ST = 3'd4
  } state_t;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  state_t           state, state_d;
  logic [BW-1:0]    bcnt, bcnt_d;
  logic [PW-1:0]    pcnt, pcnt_d;
  logic             led_d, bdone_d;
  logic             mode_chg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      tick   <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      mode_q <= mode;
      if (en) begin
        if (cnt == CNT_MAX) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        cnt  <= '0;
        tick <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      pcnt       <= '0;
      led        <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_d;
      bcnt       <= bcnt_d;
      pcnt       <= pcnt_d;
      led        <= led_d;
      burst_done <= bdone_d;
    end
  end

  // A mode change wins over a coincident tick; the FSM only consumes ticks in a stable mode.
  always_comb begin
    state_d  = state;
    bcnt_d   = bcnt;
    pcnt_d   = pcnt;
    led_d    = led;
    bdone_d  = 1'b0;
    mode_chg = (mode != mode_q);
    if (mode_chg) begin
      bcnt_d = '0;
      pcnt_d = '0;
      case (mode)
        2'b00: begin
          state_d = IDLE;
          led_d   = 1'b0;
        end
        2'b01: begin
          state_d = HOLD;
          led_d   = 1'b1;
        end
        default: begin
          state_d = ON_PH;
          led_d   = 1'b1;
        end
      endcase
    end else if (tick && en) begin
      case (state)
        ON_PH: begin
          state_d = OFF_PH;
          led_d   = 1'b0;
          if (mode_q == 2'b11) bcnt_d = bcnt + 1'b1;
        end
        OFF_PH: begin
          if (mode_q == 2'b11 && bcnt == BURST_MAX) begin
            state_d = PAUSE_ST;
            pcnt_d  = '0;
            bdone_d = 1'b1;
            led_d   = 1'b0;
          end else begin
            state_d = ON_PH;
            led_d   = 1'b1;
          end
        end
        PAUSE_ST: begin
          if (pcnt == PAUSE_MAX) begin
            state_d = ON_PH;
            bcnt_d  = '0;
            led_d   = 1'b1;
          end else begin
            pcnt_d = pcnt + 1'b1;
            led_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb/tb_blink_sequencer.sv - directed self-checking bench for blink_sequencer
// Edge k counts rising edges after reset release; outputs are sampled 1ns after each edge.
module tb_blink_sequencer;
  localparam int DIV   = 4;
  localparam int BURST = 2;
  localparam int PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       led;
  logic       tick;
  logic       burst_done;

  int n_chk  = 0;
  int n_pass = 0;
  bit [5:0] pat = 6'b000101;

  always #5 clk = ~clk;

  blink_sequencer #(
    .DIV(DIV), .CNT_W(3), .BURST(BURST), .PAUSE(PAUSE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led(led), .tick(tick), .burst_done(burst_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic e);
    rst  = 1'b0;
    mode = m;
    en   = e;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'b00;
    #2 rst = 1'b0;
    #1;
    check("rst_led", int'(led), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_bdone", int'(burst_done), 0);

    // 1: prescaler, led stays off, async reset mid-count
    do_reset(2'b00, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("t1_tick_e%0d", k), int'(tick), int'(k % 4 == 0));
      check($sformatf("t1_led_e%0d", k), int'(led), 0);
    end
    check("t1_cnt_before_rst", int'(dut.cnt), 2);
    #2 rst = 1'b0;
    #1;
    check("t1_cnt_async", int'(dut.cnt), 0);
    check("t1_tick_async", int'(tick), 0);
    check("t1_led_async", int'(led), 0);

    // 2: hold on across 5 ticks, then back to off
    do_reset(2'b01, 1'b1);
    step();
    check("t2_led_e1", int'(led), 1);
    for (int k = 2; k <= 20; k++) begin
      step();
      if (k % 4 == 0) begin
        check($sformatf("t2_tick_e%0d", k), int'(tick), 1);
        check($sformatf("t2_led_e%0d", k), int'(led), 1);
      end
    end
    mode = 2'b00;
    step();
    check("t2_led_off", int'(led), 0);

    // 3: blink toggles each tick
    do_reset(2'b10, 1'b1);
    step();
    check("t3_led_e1", int'(led), 1);
    for (int k = 2; k <= 16; k++) begin
      step();
      if (k % 4 == 0) begin
        check($sformatf("t3_tick_e%0d", k), int'(tick), 1);
        check($sformatf("t3_led_e%0d", k), int'(led), int'((k / 4) % 2));
      end
    end

    // 4: burst pattern 1,0,1,0,0,0 with burst_done on PAUSE entry, then reset in PAUSE
    do_reset(2'b11, 1'b1);
    for (int k = 1; k <= 44; k++) begin
      step();
      check($sformatf("t4_bdone_e%0d", k), int'(burst_done), int'(k == 17 || k == 41));
      if (k % 4 == 0) begin
        check($sformatf("t4_led_e%0d", k), int'(led), int'(pat[(k / 4 - 1) % 6]));
      end
    end
    check("t4_in_pause", int'(dut.state), 4);
    #2 rst = 1'b0;
    #1;
    check("t4_led_rst", int'(led), 0);
    step();
    rst = 1'b1;
    step();
    check("t4_restart_e1", int'(led), 1);
    step(); step(); step();
    check("t4_restart_e4", int'(led), 1);
    step();
    check("t4_restart_e5", int'(led), 0);

    // 5: en low freezes blink with led high
    do_reset(2'b10, 1'b1);
    step();
    step();
    check("t5_led_e2", int'(led), 1);
    en = 1'b0;
    for (int k = 3; k <= 22; k++) begin
      step();
      check($sformatf("t5_led_frz_e%0d", k), int'(led), 1);
      check($sformatf("t5_tick_frz_e%0d", k), int'(tick), 0);
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("t5_tick_resume%0d", k), int'(tick), int'(k == 4));
    end
    check("t5_led_at_tick", int'(led), 1);
    step();
    check("t5_led_after_tick", int'(led), 0);

    // 6: mode change 10->11 on the edge that would consume a tick
    do_reset(2'b10, 1'b1);
    for (int k = 1; k <= 4; k++) step();
    check("t6_tick_e4", int'(tick), 1);
    mode = 2'b11;
    step();
    check("t6_led_e5", int'(led), 1);
    check("t6_bcnt_e5", int'(dut.bcnt), 0);
    step(); step(); step();
    check("t6_tick_e8", int'(tick), 1);
    check("t6_led_e8", int'(led), 1);
    step();
    check("t6_led_e9", int'(led), 0);
    check("t6_bcnt_e9", int'(dut.bcnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
